draw_ships: RTL and testbench

// - Pixel-pipeline stage between draw_bg and draw_grid.
// - Paints the GRID_SIZE x GRID_SIZE board cells at (X_POS,Y_POS). Colour comes from each cell's state,

---
 rtl/draw_ships_if.sv | 33 +++
 rtl/draw_ships.sv | 193 +++++++++++++++++++
 tb/tb_draw_ships.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_ships_if.sv
// -----------------------------------------------------------------------------
// vga_if : VGA timing bundle passed between pixel-pipeline stages.
//
// Fields
//   vcount [10:0]  current line
//   vsync          vertical sync
//   vblnk          vertical blanking
//   hcount [10:0]  current pixel within the line
//   hsync          horizontal sync
//   hblnk          horizontal blanking
//   rgb    [11:0]  4:4:4 pixel colour
//
// Modports
//   src  : the stage that drives the bundle
//   snk  : the stage that consumes the bundle
// -----------------------------------------------------------------------------
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport src (
    output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
  );

  modport snk (
    input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
  );
endinterface

// File: rtl/draw_ships.sv
// -----------------------------------------------------------------------------
// draw_ships : paints a GRID_SIZE x GRID_SIZE board of cells whose top-left
// corner is at (X_POS, Y_POS). Each cell's colour comes from its state, read
// from an external cell memory. VGA timing is passed through with a fixed
// latency of two clocks so the next stage (grid-line overlay) stays aligned.
//
// Ports
//   clk        in   1     pixel clock
//   rst        in   1     synchronous active-high reset
//   in         vga_if     upstream timing + rgb
//   out        vga_if     timing delayed by 2 clocks, rgb possibly replaced
//   cell_addr  out  7     cell memory address = row*GRID_SIZE + col
//   cell_data  in   2     cell state for cell_addr, one clock later
//                         (0 EMPTY, 1 SHIP, 2 HIT, 3 MISS)
//
// Pipeline
//   stage 1: board hit test, cell address, in-cell pixel offsets, copy of in
//   stage 2: colour select from cell_data, registered onto out
// -----------------------------------------------------------------------------
module draw_ships #(
  parameter int          X_POS     = 100,
  parameter int          Y_POS     = 100,
  parameter int          CELL_SIZE = 32,
  parameter int          GRID_SIZE = 10,
  parameter logic [11:0] SHIP_RGB  = 12'h888,
  parameter logic [11:0] HIT_RGB   = 12'hF00,
  parameter logic [11:0] MISS_RGB  = 12'h00F
) (
  input  logic       clk,
  input  logic       rst,
  vga_if.snk         in,
  vga_if.src         out,
  output logic [6:0] cell_addr,
  input  logic [1:0] cell_data
);

  // Geometry derived from the parameters. CELL_SIZE is a power of two, so
  // the column/row index is a shift and the in-cell offset is the low bits.
  localparam int OFF_W    = $clog2(CELL_SIZE);
  localparam int BOARD_PX = GRID_SIZE * CELL_SIZE;

  localparam logic [10:0] X_LO = 11'(X_POS);
  localparam logic [10:0] X_HI = 11'(X_POS + BOARD_PX);
  localparam logic [10:0] Y_LO = 11'(Y_POS);
  localparam logic [10:0] Y_HI = 11'(Y_POS + BOARD_PX);
  localparam logic [10:0] GRID = 11'(GRID_SIZE);

  // MISS marker: an 8x8 dot centred in the cell.
  localparam logic [OFF_W-1:0] MISS_LO = OFF_W'(CELL_SIZE / 2 - 4);
  localparam logic [OFF_W-1:0] MISS_HI = OFF_W'(CELL_SIZE / 2 + 3);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_SHIP  = 2'd1;
  localparam logic [1:0] ST_HIT   = 2'd2;
  localparam logic [1:0] ST_MISS  = 2'd3;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: board hit test and cell addressing
  // ---------------------------------------------------------------------------
  logic             x_in;
  logic             y_in;
  logic             in_board;
  logic [10:0]      dx;
  logic [10:0]      dy;
  logic [10:0]      col;
  logic [10:0]      row;
  logic [6:0]       addr_next;

  // Board hit test, cell index and address for the incoming pixel.
  always_comb begin
    // Range compares are done on the raw counters, so the subtraction
    // below is only meaningful (never underflowed) when in_board is set.
    x_in     = (in.hcount >= X_LO) && (in.hcount < X_HI);
    y_in     = (in.vcount >= Y_LO) && (in.vcount < Y_HI);
    in_board = x_in && y_in && !in.hblnk && !in.vblnk;

    dx  = in.hcount - X_LO;
    dy  = in.vcount - Y_LO;
    col = dx >> OFF_W;
    row = dy >> OFF_W;

    if (in_board) begin
      // Product kept at counter width, then truncated to the address bus.
      addr_next = 7'(row * GRID + col);
    end else begin
      addr_next = 7'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic             s1_in_board;
  logic [OFF_W-1:0] s1_xoff;
  logic [OFF_W-1:0] s1_yoff;
  logic [10:0]      s1_vcount;
  logic             s1_vsync;
  logic             s1_vblnk;
  logic [10:0]      s1_hcount;
  logic             s1_hsync;
  logic             s1_hblnk;
  logic [11:0]      s1_rgb;

  // Stage 1: latch the hit flag, offsets, address and a copy of the timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_in_board <= 1'b0;
      s1_xoff     <= '0;
      s1_yoff     <= '0;
      s1_vcount   <= 11'd0;
      s1_vsync    <= 1'b0;
      s1_vblnk    <= 1'b0;
      s1_hcount   <= 11'd0;
      s1_hsync    <= 1'b0;
      s1_hblnk    <= 1'b0;
      s1_rgb      <= 12'd0;
      cell_addr   <= 7'd0;
    end else begin
      s1_in_board <= in_board;
      // Offsets come from the same subtraction as the address, so a cell
      // boundary moves col and resets the offset on the same pixel.
      s1_xoff     <= dx[OFF_W-1:0];
      s1_yoff     <= dy[OFF_W-1:0];
      s1_vcount   <= in.vcount;
      s1_vsync    <= in.vsync;
      s1_vblnk    <= in.vblnk;
      s1_hcount   <= in.hcount;
      s1_hsync    <= in.hsync;
      s1_hblnk    <= in.hblnk;
      s1_rgb      <= in.rgb;
      cell_addr   <= addr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: colour select
  // ---------------------------------------------------------------------------
  logic        miss_dot;
  logic [11:0] rgb_next;

  // Pick the pixel colour from the cell state returned by the memory.
  always_comb begin
    miss_dot = (s1_xoff >= MISS_LO) && (s1_xoff <= MISS_HI) &&
               (s1_yoff >= MISS_LO) && (s1_yoff <= MISS_HI);
    rgb_next = s1_rgb;

    // cell_data is only trusted for pixels that were on the board; the
    // memory output for address 0 is otherwise meaningless here.
    if (s1_in_board) begin
      case (cell_data)
        ST_EMPTY: rgb_next = s1_rgb;
        ST_SHIP:  rgb_next = SHIP_RGB;
        ST_HIT:   rgb_next = HIT_RGB;
        ST_MISS: begin
          if (miss_dot) begin
            rgb_next = MISS_RGB;
          end else begin
            rgb_next = s1_rgb;
          end
        end
        default:  rgb_next = s1_rgb;
      endcase
    end else begin
      rgb_next = s1_rgb;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers: drive the downstream bundle
  // ---------------------------------------------------------------------------

  // Stage 2: register the timing copy and the selected colour onto out.
  always_ff @(posedge clk) begin
    if (rst) begin
      out.vcount <= 11'd0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= 11'd0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= 12'd0;
    end else begin
      out.vcount <= s1_vcount;
      out.vsync  <= s1_vsync;
      out.vblnk  <= s1_vblnk;
      out.hcount <= s1_hcount;
      out.hsync  <= s1_hsync;
      out.hblnk  <= s1_hblnk;
      out.rgb    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_ships.sv
// -----------------------------------------------------------------------------
// tb_draw_ships : scoreboard bench for draw_ships.
// Stimulus pushes expected responses (from a board model using plain
// division/modulo) into queues; a monitor on the falling edge pops and
// compares them when they fall due.
// -----------------------------------------------------------------------------
module tb_draw_ships;

  localparam int X_POS = 100;
  localparam int Y_POS = 100;
  localparam int CELL  = 32;
  localparam int GRID  = 10;
  localparam logic [11:0] SHIP_C = 12'h888;
  localparam logic [11:0] HIT_C  = 12'hF00;
  localparam logic [11:0] MISS_C = 12'h00F;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] cell_addr;
  logic [1:0] cell_data;
  logic [1:0] board [0:127];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  vga_if vin ();
  vga_if vout ();

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Cell memory: data for the address registered on the previous edge.
  assign cell_data = board[cell_addr];

  draw_ships dut (
    .clk       (clk),
    .rst       (rst),
    .in        (vin),
    .out       (vout),
    .cell_addr (cell_addr),
    .cell_data (cell_data)
  );

  typedef struct {
    int          due;
    logic [10:0] h;
    logic [10:0] v;
    logic [3:0]  syn;   // {hsync, vsync, hblnk, vblnk}
    logic [11:0] rgb;
  } pix_t;

  typedef struct {
    int         due;
    logic [6:0] addr;
  } addr_t;

  pix_t  pix_q[$];
  addr_t addr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
  endtask

  function automatic bit on_board(int h, int v, bit hb, bit vb);
    return !hb && !vb && h >= X_POS && h < X_POS + GRID*CELL &&
           v >= Y_POS && v < Y_POS + GRID*CELL;
  endfunction

  function automatic logic [6:0] ref_addr(int h, int v, bit hb, bit vb);
    if (!on_board(h, v, hb, vb)) return 7'd0;
    return 7'((v - Y_POS) / CELL * GRID + (h - X_POS) / CELL);
  endfunction

  function automatic logic [11:0] ref_rgb(int h, int v, bit hb, bit vb, logic [11:0] bg);
    int xo, yo, idx;
    if (!on_board(h, v, hb, vb)) return bg;
    idx = (v - Y_POS) / CELL * GRID + (h - X_POS) / CELL;
    xo  = (h - X_POS) % CELL;
    yo  = (v - Y_POS) % CELL;
    case (board[idx])
      2'd1:    return SHIP_C;
      2'd2:    return HIT_C;
      2'd3:    return (xo >= CELL/2-4 && xo <= CELL/2+3 &&
                       yo >= CELL/2-4 && yo <= CELL/2+3) ? MISS_C : bg;
      default: return bg;
    endcase
  endfunction

  // Drive one pixel and queue its expected address and output.
  task automatic issue(input int h, input int v, input bit hb, input bit vb,
                       input bit hs, input bit vs, input logic [11:0] rgb);
    pix_t  p;
    addr_t a;
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.rgb    = rgb;
    p.due = cyc + 2;
    p.h   = 11'(h);
    p.v   = 11'(v);
    p.syn = {hs, vs, hb, vb};
    p.rgb = ref_rgb(h, v, hb, vb, rgb);
    a.due  = cyc + 1;
    a.addr = ref_addr(h, v, hb, vb);
    pix_q.push_back(p);
    addr_q.push_back(a);
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int h, input int v);
    issue(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));
  endtask

  // Wait (bounded) until every queued expectation has been compared.
  task automatic drain();
    int t = 0;
    while ((pix_q.size() > 0 || addr_q.size() > 0) && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (pix_q.size() > 0 || addr_q.size() > 0) begin
      chk("drain_timeout", 32'(pix_q.size() + addr_q.size()), 32'd0);
      pix_q.delete();
      addr_q.delete();
    end
  endtask

  // Hold reset with live input and confirm everything stays at zero.
  task automatic reset_phase(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      vin.hcount = 11'(100 + i);
      vin.vcount = 11'd100;
      vin.hblnk  = 1'b0;
      vin.vblnk  = 1'b0;
      vin.hsync  = 1'($urandom);
      vin.vsync  = 1'($urandom);
      vin.rgb    = 12'($urandom);
      @(posedge clk);
      #1;
      chk("reset_out", {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                        vout.hblnk, vout.vblnk}, 32'd0);
      chk("reset_rgb_addr", {13'd0, vout.rgb, cell_addr}, 32'd0);
    end
    rst = 1'b0;
  endtask

  // Monitor: compare queued expectations as they fall due.
  always @(negedge clk) begin
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      addr_t a;
      a = addr_q.pop_front();
      if (a.due != cyc) chk("addr_sched", 32'(a.due), 32'(cyc));
      else chk("cell_addr", 32'(cell_addr), 32'(a.addr));
    end
    while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      pix_t p;
      p = pix_q.pop_front();
      if (p.due != cyc) chk("pix_sched", 32'(p.due), 32'(cyc));
      else begin
        chk("out_rgb", 32'(vout.rgb), 32'(p.rgb));
        chk("out_count", {10'd0, vout.hcount, vout.vcount}, {10'd0, p.h, p.v});
        chk("out_sync", 32'({vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 32'(p.syn));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rows[$];
    for (int i = 0; i < 128; i++) board[i] = 2'd0;
    board[0] = 2'd1;
    rst = 1'b1;
    vin.hcount = 11'd0; vin.vcount = 11'd0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'd0;
    @(posedge clk);
    #1;

    // Reset held with active input.
    reset_phase(5);

    // Board origin is cell 0 (SHIP); one pixel to the left is outside.
    pixel(100, 100);
    pixel(99, 100);
    pixel(100, 99);
    pixel(131, 100);
    pixel(132, 100);
    drain();

    // Far corner, just past it, and an interior cell.
    for (int i = 0; i < 100; i++) board[i] = 2'($urandom);
    board[99] = 2'd1;
    board[21] = 2'd2;
    pixel(419, 419);
    pixel(420, 419);
    pixel(419, 420);
    pixel(132, 164);
    pixel(131, 163);
    drain();

    // MISS dot edges in cell 0.
    board[0] = 2'd3;
    pixel(112, 112);
    pixel(119, 119);
    pixel(111, 116);
    pixel(120, 116);
    pixel(116, 111);
    pixel(116, 120);
    pixel(116, 116);
    drain();

    // HIT fills the whole cell; blanking inside the board passes rgb.
    board[0] = 2'd2;
    for (int y = 100; y < 132; y++)
      for (int x = 100; x < 132; x++) pixel(x, y);
    issue(110, 110, 1'b1, 1'b0, 1'b0, 1'b0, 12'h5A5);
    issue(110, 110, 1'b0, 1'b1, 1'b0, 1'b1, 12'h3C3);
    drain();

    // Reset mid-stream, then resume.
    reset_phase(3);
    pixel(105, 105);
    pixel(300, 300);
    drain();

    // Random board, raster scan of sampled rows with blanking and sync.
    for (int i = 0; i < 100; i++) board[i] = 2'($urandom);
    for (int v = 0; v < 480; v += 8) rows.push_back(v);
    rows.push_back(99); rows.push_back(100); rows.push_back(131);
    rows.push_back(132); rows.push_back(419); rows.push_back(420);
    rows.push_back(491);
    foreach (rows[r]) begin
      for (int h = 0; h < 700; h++) begin
        int v = rows[r];
        issue(h, v, h >= 640, v >= 480, h >= 656 && h < 752, v >= 490 && v < 492,
              12'($urandom));
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
